// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
//   Hazard and stall controller for the EX stage of a five-stage MIPS pipeline.
//   It has four jobs:
//     - select the EX operand sources (register file, WB result or MEM ALU result)
//     - detect load-use hazards and flush the instruction after a taken branch
//     - hold the front of the pipe while a multi-cycle ALU op (MULT/DIV) runs
//     - drive the write, flush and bubble controls for PC, IF/ID, ID/EX and EX/MEM
//
// Parameters
//   MC_LATENCY        cycles a multi-cycle op occupies EX (legal range 3..16)
//
// Ports
//   clk               pipeline clock, rising edge
//   reset             asynchronous reset, active high
//   RsAddr_id         rs of the instruction in ID
//   RtAddr_id         rt of the instruction in ID
//   Branch_taken_id   branch or jump in ID resolved taken
//   RsAddr_ex         rs of the instruction in EX
//   RtAddr_ex         rt of the instruction in EX
//   RegWriteAddr_ex   destination register of the instruction in EX
//   MemRead_ex        the instruction in EX is a load
//   MultiCycle_ex     the instruction in EX uses the multi-cycle ALU path
//   RegWriteAddr_mem  destination register in MEM
//   RegWrite_mem      MEM writes a register
//   RegWriteAddr_wb   destination register in WB
//   RegWrite_wb       WB writes a register
//   ForwardA          A operand select: 00 register file, 01 WB data, 10 MEM ALU result
//   ForwardB          B operand select, same encoding, on the rt path
//   PC_Write          1 = PC updates
//   IF_ID_Write       1 = IF/ID loads
//   IF_ID_Flush       1 = IF/ID loads a NOP
//   ID_EX_Write       1 = ID/EX loads
//   ID_EX_Flush       1 = ID/EX loads a bubble
//   EX_MEM_Bubble     1 = EX/MEM loads a bubble (RegWrite and MemWrite cleared)
//   MC_Busy           multi-cycle op in progress; the front of the pipe is stalled
//   MC_Done           one-cycle pulse: the multi-cycle result is valid in EX
//
// Multi-cycle sequencer states
//   state | meaning
//   IDLE  | no multi-cycle op; a MultiCycle_ex request stalls from this cycle on
//   BUSY  | op running; cnt counts down to 0
//   DONE  | result valid in EX for one cycle; the pipe advances again
module ex_hazard_ctrl #(
    parameter int MC_LATENCY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] RsAddr_id,
    input  logic [4:0] RtAddr_id,
    input  logic       Branch_taken_id,
    input  logic [4:0] RsAddr_ex,
    input  logic [4:0] RtAddr_ex,
    input  logic [4:0] RegWriteAddr_ex,
    input  logic       MemRead_ex,
    input  logic       MultiCycle_ex,
    input  logic [4:0] RegWriteAddr_mem,
    input  logic       RegWrite_mem,
    input  logic [4:0] RegWriteAddr_wb,
    input  logic       RegWrite_wb,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Write,
    output logic       ID_EX_Flush,
    output logic       EX_MEM_Bubble,
    output logic       MC_Busy,
    output logic       MC_Done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mcState_t;

    localparam logic [1:0] FwdRegFile = 2'b00;
    localparam logic [1:0] FwdWb      = 2'b01;
    localparam logic [1:0] FwdMem     = 2'b10;

    // The cycle that sees the request in IDLE and the DONE cycle are both
    // part of the op's time in EX, so BUSY lasts MC_LATENCY-2 cycles.
    // Starting the down-counter at MC_LATENCY-3 and leaving BUSY on cnt==0
    // gives exactly that many BUSY cycles.
    localparam logic [3:0] CntInit = 4'(MC_LATENCY - 3);

    mcState_t   state;
    mcState_t   nextState;
    logic [3:0] cnt;
    logic [3:0] nextCnt;

    logic [1:0] fwdASel;
    logic [1:0] fwdBSel;
    logic       mcStall;
    logic       loadUse;
    logic       memHitsRs;
    logic       memHitsRt;
    logic       wbHitsRs;
    logic       wbHitsRt;

    // ------------------------------------------------------------------
    // Operand forwarding. MEM holds the newer result, so it wins over WB.
    // $0 is hardwired to zero and is never forwarded.
    // ------------------------------------------------------------------
    always_comb begin
        memHitsRs = RegWrite_mem && (RegWriteAddr_mem != 5'd0) && (RegWriteAddr_mem == RsAddr_ex);
        memHitsRt = RegWrite_mem && (RegWriteAddr_mem != 5'd0) && (RegWriteAddr_mem == RtAddr_ex);
        wbHitsRs  = RegWrite_wb  && (RegWriteAddr_wb  != 5'd0) && (RegWriteAddr_wb  == RsAddr_ex);
        wbHitsRt  = RegWrite_wb  && (RegWriteAddr_wb  != 5'd0) && (RegWriteAddr_wb  == RtAddr_ex);

        fwdASel = FwdRegFile;
        if (memHitsRs) begin
            fwdASel = FwdMem;
        end else if (wbHitsRs) begin
            fwdASel = FwdWb;
        end

        fwdBSel = FwdRegFile;
        if (memHitsRt) begin
            fwdBSel = FwdMem;
        end else if (wbHitsRt) begin
            fwdBSel = FwdWb;
        end
    end

    // ------------------------------------------------------------------
    // Hazard terms
    // ------------------------------------------------------------------
    always_comb begin
        // The stall starts in the same cycle the request is first seen in
        // IDLE so the instruction behind the op never moves.
        mcStall = ((state == IDLE) && MultiCycle_ex) || (state == BUSY);

        // Both source registers of the ID instruction are checked, since the
        // decoder does not tell us which ones are really read.
        loadUse = MemRead_ex && (RegWriteAddr_ex != 5'd0) &&
                  ((RegWriteAddr_ex == RsAddr_id) || (RegWriteAddr_ex == RtAddr_id));
    end

    // ------------------------------------------------------------------
    // Multi-cycle sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    // ------------------------------------------------------------------
    // Multi-cycle sequencer: next state
    // ------------------------------------------------------------------
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        unique case (state)
            IDLE: begin
                if (MultiCycle_ex) begin
                    nextState = BUSY;
                    nextCnt   = CntInit;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    nextState = DONE;
                end else begin
                    nextCnt = cnt - 4'd1;
                end
            end
            DONE: begin
                // The finished op is still in EX during DONE and still shows
                // MultiCycle_ex, so the request is not looked at here.
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
                nextCnt   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline controls. While reset is high every output is forced to
    // the free-running value, whatever the register state is.
    // Priority: multi-cycle stall, then load-use, then taken branch.
    // A branch that meets a load-use stall resolves again next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        ForwardA      = FwdRegFile;
        ForwardB      = FwdRegFile;
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Write   = 1'b1;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Bubble = 1'b0;
        MC_Busy       = 1'b0;
        MC_Done       = 1'b0;

        if (!reset) begin
            ForwardA = fwdASel;
            ForwardB = fwdBSel;
            MC_Busy  = mcStall;
            MC_Done  = (state == DONE);

            if (mcStall) begin
                PC_Write      = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EX_Write   = 1'b0;
                EX_MEM_Bubble = 1'b1;
            end else if (loadUse) begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Flush = 1'b1;
            end else if (Branch_taken_id) begin
                IF_ID_Flush = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl. Two instances share one set of
// inputs: one built with MC_LATENCY=4, one with MC_LATENCY=3. The stimulus
// process drives one input vector per cycle and queues the hand-computed
// outputs for that cycle, tagged with the instance to check. The monitor
// pops one entry at each falling edge and compares.
module tb_ex_hazard_ctrl;

    typedef logic [11:0] outs_t;   // {FA[1:0], FB[1:0], PC, IFW, IFF, IDW, IDF, EXB, BUSY, DONE}

    typedef struct {
        outs_t exp;
        string nm;
        bit    sel;                // 0: latency-4 instance, 1: latency-3 instance
    } item_t;

    localparam outs_t N      = 12'b0000_1101_0000;  // free-running pipe
    localparam outs_t MCS    = 12'b0000_0000_0110;  // multi-cycle stall
    localparam outs_t LU     = 12'b0000_0001_1000;  // load-use stall
    localparam outs_t BR     = 12'b0000_1111_0000;  // taken-branch flush
    localparam outs_t DN     = 12'b0000_1101_0001;  // DONE cycle
    localparam outs_t DNBR   = 12'b0000_1111_0001;  // DONE cycle with taken branch
    localparam outs_t FA_MEM = 12'b1000_1101_0000;
    localparam outs_t FA_WB  = 12'b0100_1101_0000;
    localparam outs_t FAWB_FBMEM = 12'b0110_1101_0000;
    localparam outs_t FB_MEM = 12'b0010_1101_0000;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] RsAddr_id, RtAddr_id, RsAddr_ex, RtAddr_ex;
    logic [4:0] RegWriteAddr_ex, RegWriteAddr_mem, RegWriteAddr_wb;
    logic       Branch_taken_id, MemRead_ex, MultiCycle_ex, RegWrite_mem, RegWrite_wb;

    logic [1:0] fa4, fb4, fa3, fb3;
    logic       pc4, ifw4, iff4, idw4, idf4, exb4, busy4, done4;
    logic       pc3, ifw3, iff3, idw3, idf3, exb3, busy3, done3;

    outs_t act4, act3;
    assign act4 = {fa4, fb4, pc4, ifw4, iff4, idw4, idf4, exb4, busy4, done4};
    assign act3 = {fa3, fb3, pc3, ifw3, iff3, idw3, idf3, exb3, busy3, done3};

    item_t expQ[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.MC_LATENCY(4)) dutLat4 (
        .clk(clk), .reset(reset),
        .RsAddr_id(RsAddr_id), .RtAddr_id(RtAddr_id), .Branch_taken_id(Branch_taken_id),
        .RsAddr_ex(RsAddr_ex), .RtAddr_ex(RtAddr_ex), .RegWriteAddr_ex(RegWriteAddr_ex),
        .MemRead_ex(MemRead_ex), .MultiCycle_ex(MultiCycle_ex),
        .RegWriteAddr_mem(RegWriteAddr_mem), .RegWrite_mem(RegWrite_mem),
        .RegWriteAddr_wb(RegWriteAddr_wb), .RegWrite_wb(RegWrite_wb),
        .ForwardA(fa4), .ForwardB(fb4), .PC_Write(pc4), .IF_ID_Write(ifw4),
        .IF_ID_Flush(iff4), .ID_EX_Write(idw4), .ID_EX_Flush(idf4),
        .EX_MEM_Bubble(exb4), .MC_Busy(busy4), .MC_Done(done4)
    );

    ex_hazard_ctrl #(.MC_LATENCY(3)) dutLat3 (
        .clk(clk), .reset(reset),
        .RsAddr_id(RsAddr_id), .RtAddr_id(RtAddr_id), .Branch_taken_id(Branch_taken_id),
        .RsAddr_ex(RsAddr_ex), .RtAddr_ex(RtAddr_ex), .RegWriteAddr_ex(RegWriteAddr_ex),
        .MemRead_ex(MemRead_ex), .MultiCycle_ex(MultiCycle_ex),
        .RegWriteAddr_mem(RegWriteAddr_mem), .RegWrite_mem(RegWrite_mem),
        .RegWriteAddr_wb(RegWriteAddr_wb), .RegWrite_wb(RegWrite_wb),
        .ForwardA(fa3), .ForwardB(fb3), .PC_Write(pc3), .IF_ID_Write(ifw3),
        .IF_ID_Flush(iff3), .ID_EX_Write(idw3), .ID_EX_Flush(idf3),
        .EX_MEM_Bubble(exb3), .MC_Busy(busy3), .MC_Done(done3)
    );

    // Monitor: one expected entry per cycle, checked mid-cycle.
    initial begin
        item_t it;
        outs_t act;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                it  = expQ.pop_front();
                act = it.sel ? act3 : act4;
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL %s (lat%0d): got %b want %b", it.nm, it.sel ? 3 : 4, act, it.exp);
                end
            end
        end
    end

    // Queue this cycle's expectation, then move to just after the next edge.
    task automatic apply(input outs_t e, input string nm, input bit sel);
        item_t it;
        it.exp = e;
        it.nm  = nm;
        it.sel = sel;
        expQ.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        RsAddr_id = 0; RtAddr_id = 0; Branch_taken_id = 0;
        RsAddr_ex = 0; RtAddr_ex = 0; RegWriteAddr_ex = 0;
        MemRead_ex = 0; MultiCycle_ex = 0;
        RegWriteAddr_mem = 0; RegWrite_mem = 0;
        RegWriteAddr_wb = 0; RegWrite_wb = 0;
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        @(posedge clk);
        #1;

        // Reset forces outputs even with forwarding, load-use and MC requests present
        RsAddr_ex = 5; RegWriteAddr_mem = 5; RegWrite_mem = 1;
        MemRead_ex = 1; RegWriteAddr_ex = 8; RtAddr_id = 8; MultiCycle_ex = 1;
        apply(N, "reset_forced", 0);
        clearInputs();
        reset = 1'b0;
        apply(N, "after_reset", 0);

        // Forwarding
        RsAddr_ex = 5; RegWriteAddr_mem = 5; RegWrite_mem = 1; RegWriteAddr_wb = 5; RegWrite_wb = 1;
        apply(FA_MEM, "fwdA_mem_priority", 0);
        RegWrite_mem = 0;
        apply(FA_WB, "fwdA_wb", 0);
        RsAddr_ex = 0; RegWriteAddr_mem = 0; RegWrite_mem = 1; RegWriteAddr_wb = 0;
        apply(N, "fwd_r0_never", 0);
        RsAddr_ex = 3; RtAddr_ex = 7; RegWriteAddr_mem = 7; RegWriteAddr_wb = 3;
        apply(FAWB_FBMEM, "fwdA_wb_fwdB_mem", 0);
        RegWrite_wb = 0;
        apply(FB_MEM, "fwdB_mem_only", 0);
        clearInputs();

        // Load-use and branch
        MemRead_ex = 1; RegWriteAddr_ex = 8; RtAddr_id = 8;
        apply(LU, "lu_rt", 0);
        MemRead_ex = 0;
        apply(N, "lu_released", 0);
        MemRead_ex = 1; RegWriteAddr_ex = 9; RsAddr_id = 9; RtAddr_id = 0;
        apply(LU, "lu_rs", 0);
        RegWriteAddr_ex = 0; RsAddr_id = 0;
        apply(N, "lu_r0_ignored", 0);
        RegWriteAddr_ex = 9; RsAddr_id = 9; MemRead_ex = 0;
        apply(N, "no_lu_without_load", 0);
        MemRead_ex = 1; Branch_taken_id = 1;
        apply(LU, "lu_beats_branch", 0);
        MemRead_ex = 0;
        apply(BR, "branch_flush", 0);
        clearInputs();

        // Multi-cycle op, latency 4, request held high through DONE
        MultiCycle_ex = 1;
        apply(MCS, "mc_c1_idle", 0);
        apply(MCS, "mc_c2_busy", 0);
        apply(MCS, "mc_c3_busy", 0);
        apply(DN,  "mc_c4_done", 0);
        MultiCycle_ex = 0;
        apply(N,   "mc_back_idle", 0);

        // Stall suppresses load-use and branch flush
        MultiCycle_ex = 1; Branch_taken_id = 1; MemRead_ex = 1; RegWriteAddr_ex = 8; RtAddr_id = 8;
        apply(MCS, "mcs_supp_c1", 0);
        apply(MCS, "mcs_supp_c2", 0);
        apply(MCS, "mcs_supp_c3", 0);
        MemRead_ex = 0;
        apply(DNBR, "done_with_branch", 0);
        MultiCycle_ex = 0;
        apply(BR, "branch_after_done", 0);
        clearInputs();

        // Reset during the second BUSY cycle abandons the op
        MultiCycle_ex = 1;
        apply(MCS, "rst_mc_c1", 0);
        apply(MCS, "rst_mc_busy1", 0);
        reset = 1'b1;
        apply(N, "rst_mid_busy", 0);
        reset = 1'b0; MultiCycle_ex = 0;
        apply(N, "rst_no_done_a", 0);
        apply(N, "rst_no_done_b", 0);
        MultiCycle_ex = 1;
        apply(MCS, "fresh_c1", 0);
        apply(MCS, "fresh_c2", 0);
        apply(MCS, "fresh_c3", 0);
        apply(DN,  "fresh_done", 0);
        MultiCycle_ex = 0;
        apply(N,   "fresh_idle", 0);

        // Latency 3: back-to-back ops, DONE does not retrigger
        reset = 1'b1;
        apply(N, "lat3_reset", 1);
        reset = 1'b0;
        apply(N, "lat3_idle", 1);
        MultiCycle_ex = 1;
        apply(MCS, "lat3_op1_idle", 1);
        apply(MCS, "lat3_op1_busy", 1);
        apply(DN,  "lat3_op1_done", 1);
        apply(MCS, "lat3_op2_idle", 1);
        apply(MCS, "lat3_op2_busy", 1);
        apply(DN,  "lat3_op2_done", 1);
        MultiCycle_ex = 0;
        apply(N,   "lat3_back_idle", 1);

        @(posedge clk);
        @(posedge clk);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: left %0d want 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
